i2c_reg_sequencer: RTL
======================

# i2c_reg_sequencer

Command-level front end for the bit-level I2C master. Accepts single-register read/write commands from the host, drives the master's `address`/`register`/`mode`/`en`/`Start`/`Stop`/`repeat_start` inputs, and monitors its `ack` pulses. It returns read data or an error, and returns the master to idle after every transaction.

## Interface
- `TIMEOUT_CYC`, default 64: max clk cycles between consecutive master `ack` pulses before the transaction is declared failed.
- `TW`, default 7: width of the phase timer; must hold TIMEOUT_CYC.
- `clk` in 1: system clock, same clock as the I2C master.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_rw` in 1: 0 = write, 1 = read.
- `cmd_dev` in 7: 7-bit device address.
- `cmd_reg` in 8: register pointer byte.
- `cmd_wdata` in 8: write data byte (ignored on read).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 1: qualified by `rsp_valid`; 1 = timeout or NACK.
- `rsp_data` out 8: read byte; qualified by `rsp_valid` with `cmd_rw`=1; holds its value otherwise.
- `i2c_address` out 7: to master `address`.
- `i2c_register` out 8: to master `register` (byte being transmitted).
- `i2c_mode` out 1: to master `mode`.
- `i2c_en` out 1: to master `en`.
- `i2c_start` out 1: to master `Start`.
- `i2c_stop` out 1: to master `Stop`.
- `i2c_repeat_start` out 1: to master `repeat_start`.
- `i2c_rst` out 1: active-low reset drive to the master; pulsed low for one cycle to return it to idle.
- `i2c_out` in 8: master `out`.
- `i2c_ack` in 1: master `ack` (one-cycle pulse per byte/ack slot).

## Operation
- States: IDLE, ADDR_W, PTR, DATA_W, RESTART, ADDR_R, READ, CAPTURE, FINISH, ERR.
- Handshake: accept on `cmd_valid & cmd_ready`. Latch all `cmd_*` fields. Go to ADDR_W.
- ADDR_W: `i2c_address`=dev, `i2c_mode`=0, `i2c_en`=1, `i2c_start`=1. On `i2c_ack`, go to PTR.
- PTR: `i2c_register`=reg, `i2c_start`=0.
  - Read: assert `i2c_repeat_start`.
  - Write: assert nothing extra.
  - On `i2c_ack`: write goes to DATA_W; read goes to RESTART.
- DATA_W: `i2c_register`=wdata, `i2c_stop`=1. On `i2c_ack`, go to FINISH.
- RESTART: one cycle. Set `i2c_mode`=1, `i2c_start`=1, `i2c_repeat_start`=0. Go to ADDR_R.
- ADDR_R: on `i2c_ack`, go to READ and set `i2c_stop`=1.
- READ: on `i2c_ack`, go to CAPTURE.
- CAPTURE: register `rsp_data`=`i2c_out`. The master's last bit lands on the ack cycle, so capture happens one cycle after the ack. Go to FINISH.
- FINISH: pulse `rsp_valid` (`rsp_err`=0) and `i2c_rst`=0. Clear all `i2c_*` drives. Go to IDLE.
- Timeout:
  - The phase timer clears on state entry and on every `i2c_ack`, and counts otherwise in ADDR_W through READ.
  - Reaching TIMEOUT_CYC sends the FSM to ERR.
  - A NACK leaves the master stuck in its stop state, so it surfaces as a timeout.
- ERR: pulse `rsp_valid` with `rsp_err`=1 and `i2c_rst`=0. Clear drives. Go to IDLE. `rsp_data` is unchanged.
- An `i2c_ack` arriving in IDLE, RESTART, CAPTURE, FINISH or ERR is ignored.
- `cmd_valid` while busy: the command is held off (`cmd_ready`=0), not dropped.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset, 1 the first cycle after.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0.
  - All `i2c_*` drives 0, except `i2c_rst`=1.
  - State = IDLE, timer = 0.
- Accept-to-drive latency: 1 cycle. `i2c_start` is high in the cycle after acceptance.
- `i2c_rst` low pulse and `rsp_valid` are coincident. `cmd_ready` rises the following cycle, giving a 1-cycle minimum gap between transactions.
- Reset mid-transaction: immediate return to IDLE. No `rsp_valid` is issued. `i2c_rst` returns to 1 and all drives go to 0.
- Timeout boundary: ERR is entered on the cycle the timer equals TIMEOUT_CYC−1 with no ack. An ack in that same cycle wins.

## Structure
- `i2c_seq_pkg`: state enum, `RW_WRITE`/`RW_READ` constants, default TIMEOUT_CYC.
- Sub-module `i2c_phase_timer`: TW-bit counter with clear/enable inputs and a `expired` output.

## Test plan
- Write: dev 0x48, reg 0x01, wdata 0xA5; bench model acks each phase after 20 cycles.
  - Expect `i2c_register` = 0x01 then 0xA5, and `i2c_stop` high in DATA_W.
  - Expect one `rsp_valid`, `rsp_err`=0.
- Read: dev 0x48, reg 0x10; model returns 0x3C.
  - Expect `repeat_start` during PTR and `mode`=1 from RESTART.
  - Expect `rsp_data`=0x3C, `rsp_err`=0.
- Address NACK: model never acks.
  - Expect `rsp_valid` with `rsp_err`=1 exactly TIMEOUT_CYC cycles after entering ADDR_W.
  - Expect `i2c_rst` low for that one cycle.
- `cmd_valid` held high through a transaction → second command accepted only the cycle after the first completes; both complete.
- `reset` asserted in READ → next cycle IDLE, all drives 0, no `rsp_valid`. A fresh write then completes normally.
- Ack on the last timeout cycle → no error, progress to the next state.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// ============================================================================
// Module      : i2c_seq_pkg
// Description : Shared types and constants for the I2C register sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package i2c_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR_W  = 4'd1,
    S_PTR     = 4'd2,
    S_DATA_W  = 4'd3,
    S_RESTART = 4'd4,
    S_ADDR_R  = 4'd5,
    S_READ    = 4'd6,
    S_CAPTURE = 4'd7,
    S_FINISH  = 4'd8,
    S_ERR     = 4'd9
  } state_t;

  localparam logic RW_WRITE        = 1'b0;
  localparam logic RW_READ         = 1'b1;
  localparam int   DEF_TIMEOUT_CYC = 64;

endpackage

`default_nettype wire

// File: rtl/i2c_phase_timer.sv
// ============================================================================
// Module      : i2c_phase_timer
// Description : Phase watchdog counter; expired flags the last allowed cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module i2c_phase_timer #(
  parameter int TW    = 7,
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TW-1:0] c_last_cnt = TW'(LIMIT - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == c_last_cnt);

endmodule

`default_nettype wire

// File: rtl/i2c_reg_sequencer.sv
// ============================================================================
// Module      : i2c_reg_sequencer
// Description : Single-register read/write command front end for an I2C master.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TW          = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_rw,
  input  logic [6:0] i_cmd_dev,
  input  logic [7:0] i_cmd_reg,
  input  logic [7:0] i_cmd_wdata,
  output logic       o_rsp_valid,
  output logic       o_rsp_err,
  output logic [7:0] o_rsp_data,
  output logic [6:0] o_i2c_address,
  output logic [7:0] o_i2c_register,
  output logic       o_i2c_mode,
  output logic       o_i2c_en,
  output logic       o_i2c_start,
  output logic       o_i2c_stop,
  output logic       o_i2c_repeat_start,
  output logic       o_i2c_rst,
  input  logic [7:0] i_i2c_out,
  input  logic       i_i2c_ack
);

  state_t     r_state;
  state_t     w_next;
  logic       r_rw;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [7:0] r_wdata;
  logic [7:0] r_rsp_data;
  logic       w_accept;
  logic       w_timed;
  logic       w_expired;
  logic       w_tmr_clr;

  assign o_cmd_ready = (r_state == S_IDLE) && !reset;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_timed     = (r_state == S_ADDR_W) || (r_state == S_PTR) || (r_state == S_DATA_W) ||
                       (r_state == S_ADDR_R) || (r_state == S_READ);
  // Clearing on any transition gives every phase a fresh budget from its first cycle.
  assign w_tmr_clr   = i_i2c_ack || (w_next != r_state);

  i2c_phase_timer #(
    .TW    (TW),
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_tmr_clr),
    .i_en      (w_timed),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rw       <= RW_WRITE;
      r_dev      <= '0;
      r_reg      <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rw    <= i_cmd_rw;
        r_dev   <= i_cmd_dev;
        r_reg   <= i_cmd_reg;
        r_wdata <= i_cmd_wdata;
      end
      // The final data bit settles on the ack cycle, so sample one cycle later.
      if (r_state == S_CAPTURE) begin
        r_rsp_data <= i_i2c_out;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_accept) w_next = S_ADDR_W;
      S_ADDR_W:  if (i_i2c_ack) w_next = S_PTR;
                 else if (w_expired) w_next = S_ERR;
      S_PTR:     if (i_i2c_ack) w_next = (r_rw == RW_READ) ? S_RESTART : S_DATA_W;
                 else if (w_expired) w_next = S_ERR;
      S_DATA_W:  if (i_i2c_ack) w_next = S_FINISH;
                 else if (w_expired) w_next = S_ERR;
      S_RESTART: w_next = S_ADDR_R;
      S_ADDR_R:  if (i_i2c_ack) w_next = S_READ;
                 else if (w_expired) w_next = S_ERR;
      S_READ:    if (i_i2c_ack) w_next = S_CAPTURE;
                 else if (w_expired) w_next = S_ERR;
      S_CAPTURE: w_next = S_FINISH;
      S_FINISH:  w_next = S_IDLE;
      S_ERR:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_i2c_address      = '0;
    o_i2c_register     = '0;
    o_i2c_mode         = 1'b0;
    o_i2c_en           = 1'b0;
    o_i2c_start        = 1'b0;
    o_i2c_stop         = 1'b0;
    o_i2c_repeat_start = 1'b0;
    o_i2c_rst          = 1'b1;
    o_rsp_valid        = 1'b0;
    o_rsp_err          = 1'b0;
    unique case (r_state)
      S_ADDR_W: begin
        o_i2c_address = r_dev;
        o_i2c_en      = 1'b1;
        o_i2c_start   = 1'b1;
      end
      S_PTR: begin
        o_i2c_address      = r_dev;
        o_i2c_register     = r_reg;
        o_i2c_en           = 1'b1;
        o_i2c_repeat_start = (r_rw == RW_READ);
      end
      S_DATA_W: begin
        o_i2c_address  = r_dev;
        o_i2c_register = r_wdata;
        o_i2c_en       = 1'b1;
        o_i2c_stop     = 1'b1;
      end
      S_RESTART, S_ADDR_R: begin
        o_i2c_address  = r_dev;
        o_i2c_register = r_reg;
        o_i2c_en       = 1'b1;
        o_i2c_mode     = 1'b1;
        o_i2c_start    = 1'b1;
      end
      S_READ, S_CAPTURE: begin
        o_i2c_address  = r_dev;
        o_i2c_register = r_reg;
        o_i2c_en       = 1'b1;
        o_i2c_mode     = 1'b1;
        o_i2c_start    = 1'b1;
        o_i2c_stop     = 1'b1;
      end
      S_FINISH: begin
        o_i2c_rst   = 1'b0;
        o_rsp_valid = 1'b1;
      end
      S_ERR: begin
        o_i2c_rst   = 1'b0;
        o_rsp_valid = 1'b1;
        o_rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_rsp_data = r_rsp_data;

endmodule

`default_nettype wire
